// File: rtl/bram_capture_if.sv
// Bus bundle for bram_capture: capture-side input, software read path and status outputs.
interface bram_capture_if #(
  parameter int DATA_WIDTH    = 64,
  parameter int RAM_ADDR_NBIT = 5
);
  logic                     i_enable;
  logic                     i_valid;
  logic [DATA_WIDTH-1:0]    i_data;
  logic                     i_read_enable;
  logic [RAM_ADDR_NBIT-1:0] i_read_address;
  logic [DATA_WIDTH-1:0]    o_read_data;
  logic                     o_read_valid;
  logic [RAM_ADDR_NBIT:0]   o_write_count;
  logic                     o_capturing;
  logic                     o_full;

  modport master (
    output i_enable, i_valid, i_data, i_read_enable, i_read_address,
    input  o_read_data, o_read_valid, o_write_count, o_capturing, o_full
  );

  modport slave (
    input  i_enable, i_valid, i_data, i_read_enable, i_read_address,
    output o_read_data, o_read_valid, o_write_count, o_capturing, o_full
  );
endinterface

// File: rtl/bram_capture.sv
// Capture buffer: fills a simple dual-port RAM with valid words after enable rises.
// Define BRAM_TRIGGER_EN to require i_data[7:0]==TRIG_PATTERN before capture starts.
module bram_capture #(
  parameter int          DATA_WIDTH    = 64,
  parameter int          RAM_ADDR_NBIT = 5,
  parameter logic [7:0]  TRIG_PATTERN  = 8'h1E
) (
  input logic            i_clock,
  input logic            i_reset,
  bram_capture_if.slave  bus
);

  localparam int DEPTH = 2 ** RAM_ADDR_NBIT;
  localparam logic [RAM_ADDR_NBIT:0] LAST_COUNT = (RAM_ADDR_NBIT + 1)'(DEPTH - 1);

`ifdef BRAM_TRIGGER_EN
  localparam bit TRIG_EN = 1'b1;
`else
  localparam bit TRIG_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, FULL} state_e;

  state_e                   state_q, state_d;
  logic                     en_prev_q;
  logic [RAM_ADDR_NBIT:0]   count_q, count_d;
  logic                     wr_en;
  logic [RAM_ADDR_NBIT-1:0] wr_addr;
  logic                     en_rise;
  logic                     trig_hit;

  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]    rd_data_q;
  logic                     rd_vld_q;

  assign en_rise  = bus.i_enable && !en_prev_q;
  assign trig_hit = bus.i_valid && (!TRIG_EN || (bus.i_data[7:0] == TRIG_PATTERN));
  // The count doubles as the write pointer; it never wraps because FULL stops writes.
  assign wr_addr  = count_q[RAM_ADDR_NBIT-1:0];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= IDLE;
      en_prev_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      en_prev_q <= bus.i_enable;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_rise) state_d = ARMED;
      ARMED, CAPTURE: begin
        if (!bus.i_enable)  state_d = IDLE;
        else if (wr_en)     state_d = (count_q == LAST_COUNT) ? FULL : CAPTURE;
      end
      FULL:    if (!bus.i_enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    count_d = count_q;
    case (state_q)
      IDLE:    if (en_rise) count_d = '0;
      ARMED:   wr_en = bus.i_enable && trig_hit && !i_reset;
      CAPTURE: wr_en = bus.i_enable && bus.i_valid && !i_reset;
      default: wr_en = 1'b0;
    endcase
    if (wr_en) count_d = count_q + 1'b1;
  end

  // RAM write port, no reset so it maps onto block RAM.
  always_ff @(posedge i_clock) begin
    if (wr_en) mem_q[wr_addr] <= bus.i_data;
  end

  // Registered read port; read-first against a same-cycle write by construction.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      rd_vld_q <= bus.i_read_enable;
      if (bus.i_read_enable) rd_data_q <= mem_q[bus.i_read_address];
    end
  end

  assign bus.o_read_data   = rd_data_q;
  assign bus.o_read_valid  = rd_vld_q;
  assign bus.o_write_count = count_q;
  assign bus.o_capturing   = (state_q == CAPTURE);
  assign bus.o_full        = (state_q == FULL);

endmodule
